bus_master_ctrl: RTL and testbench

- Master-side bus interface controller. It sits directly upstream of the two-master split-capable bus arbiter and connects to one master slot: its breq drives breqN, and it consumes bgrantN, msplitN and split_grant.
- It accepts single read/write requests from a master core and performs the bus request/grant handshake.
- It runs the address and data phases against the selected slave, and handles split release and resume.

---
 rtl/bus_master_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_bus_master_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: master-side bus interface controller.
// It takes single read/write requests from a master core, requests the bus
// from the split-capable arbiter, runs the address and data phases against
// the selected slave, and handles split release/resume.
//
// Optional feature: define BMC_TIMEOUT_EN to abort a transfer (rsp_err=1)
// that has waited TIMEOUT_CYC cycles in REQ or SPLIT.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       core request handshake
//   req_write/addr/wdata      core request payload
//   rsp_valid/rdata/err       one-cycle completion pulse, read data, abort flag
//   breq/bgrant               arbiter request/grant
//   msplit/split_grant        arbiter split notification and resume
//   mvalid/mwrite/maddr/mwdata bus transfer outputs
//   sready/srdata             selected slave ready and read data
//   split_cnt                 saturating count of split events
module bus_master_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              breq,
    input  logic              bgrant,
    input  logic              msplit,
    input  logic              split_grant,
    output logic              mvalid,
    output logic              mwrite,
    output logic [ADDR_W-1:0] maddr,
    output logic [DATA_W-1:0] mwdata,
    input  logic              sready,
    input  logic [DATA_W-1:0] srdata,
    output logic [7:0]        split_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_SPLIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [7:0]        split_q;

    logic accept;
    logic data_done;
    logic split_hit;
    logic wait_expired;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        data_done = 1'b0;
        split_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bgrant)
                    state_nxt = S_ADDR;
                else if (wait_expired)
                    state_nxt = S_DONE;
            end
            S_ADDR: state_nxt = S_DATA;
            S_DATA: begin
                if (msplit) begin
                    split_hit = 1'b1;
                    state_nxt = S_SPLIT;
                end else if (!bgrant) begin
                    // Grant lost: the address phase is restarted from REQ.
                    state_nxt = S_REQ;
                end else if (sready) begin
                    data_done = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_SPLIT: begin
                // Resume straight into DATA; the slave retains the address.
                if (split_grant && bgrant)
                    state_nxt = S_DATA;
                else if (wait_expired)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Request latches, read data capture and split counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            split_q <= '0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (data_done && !write_q)
                rdata_q <= srdata;
            if (split_hit && split_q != 8'hFF)
                split_q <= split_q + 8'd1;
        end
    end

`ifdef BMC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Counts only while staying in REQ/SPLIT, so it is zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if ((state == S_REQ || state == S_SPLIT) && state_nxt == state)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // DONE reached from anywhere but DATA can only be a timeout abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if (state_nxt == S_DONE && state != S_DATA)
            err_q <= 1'b1;
    end

    assign rsp_err = (state == S_DONE) && err_q;
`else
    // TIMEOUT_CYC is a non-negative count, so this folds to 0: no timeout.
    assign wait_expired = (TIMEOUT_CYC < 0);
    assign rsp_err      = 1'b0;
`endif

    // Outputs decode directly from the state register and the latches.
    assign req_ready = (state == S_IDLE);
    assign breq      = (state == S_REQ) || (state == S_ADDR) || (state == S_DATA);
    assign mvalid    = (state == S_ADDR) || (state == S_DATA);
    assign rsp_valid = (state == S_DONE);
    assign mwrite    = write_q;
    assign maddr     = addr_q;
    assign mwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign split_cnt = split_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb_bus_master_ctrl: self-checking bench for bus_master_ctrl.
// A cycle-by-cycle vector table covers write, read with slave wait states,
// ignored requests while busy and read-data retention; hand-written sequences
// cover split/resume, grant loss, asynchronous reset and the grant-wait
// behaviour with and without BMC_TIMEOUT_EN.
module tb_bus_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        breq;
    logic        bgrant;
    logic        msplit;
    logic        split_grant;
    logic        mvalid;
    logic        mwrite;
    logic [15:0] maddr;
    logic [7:0]  mwdata;
    logic        sready;
    logic [7:0]  srdata;
    logic [7:0]  split_cnt;

    bus_master_ctrl #(
        .ADDR_W(16),
        .DATA_W(8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .breq(breq),
        .bgrant(bgrant),
        .msplit(msplit),
        .split_grant(split_grant),
        .mvalid(mvalid),
        .mwrite(mwrite),
        .maddr(maddr),
        .mwdata(mwdata),
        .sready(sready),
        .srdata(srdata),
        .split_cnt(split_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One record per clock: inputs applied before the edge, expected
    // outputs observed just after it.
    typedef struct {
        logic        rv;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        bg;
        logic        sr;
        logic [7:0]  srd;
        logic        e_rdy;
        logic        e_breq;
        logic        e_mv;
        logic        e_rsp;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        logic        chk_rd;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int bad;
        int cnt;

        //           rv wr addr      wd     bg sr srd     rdy breq mv rsp e_addr   e_wd   crd e_rd
        // Write, bgrant/sready high: REQ, ADDR, DATA, DONE
        tbl[0]  = '{1, 1, 16'h0012, 8'hA5, 1, 1, 8'h00, 0, 1, 0, 0, 16'h0000, 8'h00, 0, 8'h00};
        tbl[1]  = '{0, 1, 16'h0012, 8'hA5, 1, 1, 8'h00, 0, 1, 1, 0, 16'h0012, 8'hA5, 0, 8'h00};
        tbl[2]  = '{0, 1, 16'h0012, 8'hA5, 1, 1, 8'h00, 0, 1, 1, 0, 16'h0012, 8'hA5, 0, 8'h00};
        tbl[3]  = '{0, 1, 16'h0012, 8'hA5, 1, 1, 8'h00, 0, 0, 0, 1, 16'h0000, 8'h00, 1, 8'h00};
        tbl[4]  = '{0, 0, 16'h0000, 8'h00, 1, 1, 8'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00};
        // Read, sready low for the first 3 DATA cycles; a busy-time request is ignored
        tbl[5]  = '{1, 0, 16'h0100, 8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 16'h0000, 8'h00, 0, 8'h00};
        tbl[6]  = '{0, 0, 16'h0100, 8'h00, 1, 0, 8'h00, 0, 1, 1, 0, 16'h0100, 8'h00, 0, 8'h00};
        tbl[7]  = '{0, 0, 16'h0100, 8'h00, 1, 0, 8'h00, 0, 1, 1, 0, 16'h0100, 8'h00, 0, 8'h00};
        tbl[8]  = '{1, 1, 16'hBEEF, 8'hEE, 1, 0, 8'h00, 0, 1, 1, 0, 16'h0100, 8'h00, 0, 8'h00};
        tbl[9]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 0, 1, 1, 0, 16'h0100, 8'h00, 0, 8'h00};
        tbl[10] = '{0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 0, 1, 1, 0, 16'h0100, 8'h00, 0, 8'h00};
        tbl[11] = '{0, 0, 16'h0000, 8'h00, 1, 1, 8'h3C, 0, 0, 0, 1, 16'h0000, 8'h00, 1, 8'h3C};
        // Request during DONE is ignored; accepted one cycle later
        tbl[12] = '{1, 1, 16'h00FF, 8'h5A, 1, 1, 8'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 1, 8'h3C};
        tbl[13] = '{1, 1, 16'h00FF, 8'h5A, 1, 1, 8'h00, 0, 1, 0, 0, 16'h0000, 8'h00, 0, 8'h00};
        tbl[14] = '{0, 1, 16'h00FF, 8'h5A, 1, 1, 8'h00, 0, 1, 1, 0, 16'h00FF, 8'h5A, 0, 8'h00};
        tbl[15] = '{0, 1, 16'h00FF, 8'h5A, 1, 1, 8'h00, 0, 1, 1, 0, 16'h00FF, 8'h5A, 0, 8'h00};
        // Write completion keeps the previous read data
        tbl[16] = '{0, 1, 16'h00FF, 8'h5A, 1, 1, 8'h00, 0, 0, 0, 1, 16'h0000, 8'h00, 1, 8'h3C};
        tbl[17] = '{0, 0, 16'h0000, 8'h00, 1, 1, 8'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00};

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        bgrant      = 1'b0;
        msplit      = 1'b0;
        split_grant = 1'b0;
        sready      = 1'b0;
        srdata      = '0;
        cyc();
        cyc();

        chk("reset req_ready", req_ready, 1);
        chk("reset breq", breq, 0);
        chk("reset mvalid", mvalid, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset mwrite", mwrite, 0);
        chk("reset maddr", maddr, 0);
        chk("reset mwdata", mwdata, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset split_cnt", split_cnt, 0);
        rst = 1'b0;
        cyc();

        // ---------------- table-driven transfers ----------------
        for (int i = 0; i < 18; i++) begin
            req_valid = tbl[i].rv;
            req_write = tbl[i].wr;
            req_addr  = tbl[i].addr;
            req_wdata = tbl[i].wd;
            bgrant    = tbl[i].bg;
            sready    = tbl[i].sr;
            srdata    = tbl[i].srd;
            cyc();
            chk($sformatf("v%0d req_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d breq", i), breq, tbl[i].e_breq);
            chk($sformatf("v%0d mvalid", i), mvalid, tbl[i].e_mv);
            chk($sformatf("v%0d rsp_valid", i), rsp_valid, tbl[i].e_rsp);
            chk($sformatf("v%0d rsp_err", i), rsp_err, 0);
            if (tbl[i].e_mv) begin
                chk($sformatf("v%0d maddr", i), maddr, tbl[i].e_addr);
                chk($sformatf("v%0d mwdata", i), mwdata, tbl[i].e_wd);
            end
            if (tbl[i].chk_rd)
                chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, tbl[i].e_rd);
        end

        // ---------------- split and resume ----------------
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0200;
        bgrant = 1'b1; sready = 1'b0;
        cyc();                       // REQ
        req_valid = 1'b0;
        cyc();                       // ADDR
        cyc();                       // DATA
        chk("split pre mvalid", mvalid, 1);
        msplit = 1'b1;
        cyc();                       // SPLIT
        msplit = 1'b0;
        bgrant = 1'b0;
        chk("split breq", breq, 0);
        chk("split mvalid", mvalid, 0);
        chk("split split_cnt", split_cnt, 1);
        chk("split maddr held", maddr, 16'h0200);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            // split_grant without bgrant must not resume
            split_grant = (i == 4);
            cyc();
            if (breq !== 1'b0 || mvalid !== 1'b0 || rsp_valid !== 1'b0)
                bad++;
        end
        chk("split wait idle-bus cycles", bad, 0);
        split_grant = 1'b1; bgrant = 1'b1;
        cyc();                       // DATA, no ADDR phase
        split_grant = 1'b0;
        chk("resume breq", breq, 1);
        chk("resume mvalid", mvalid, 1);
        chk("resume maddr", maddr, 16'h0200);
        sready = 1'b1; srdata = 8'h77;
        cyc();                       // DONE directly from resumed DATA
        chk("resume rsp_valid", rsp_valid, 1);
        chk("resume rsp_rdata", rsp_rdata, 8'h77);
        sready = 1'b0;
        cyc();
        chk("resume back idle", req_ready, 1);

        // ---------------- grant loss ----------------
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0300; req_wdata = 8'h11;
        bgrant = 1'b1; sready = 1'b0;
        cyc();                       // REQ
        req_valid = 1'b0;
        cyc();                       // ADDR
        cyc();                       // DATA
        bgrant = 1'b0;
        cyc();                       // REQ
        chk("gloss1 breq", breq, 1);
        chk("gloss1 mvalid", mvalid, 0);
        cyc();                       // still REQ
        chk("gloss2 mvalid", mvalid, 0);
        chk("gloss2 breq", breq, 1);
        bgrant = 1'b1;
        cyc();                       // ADDR re-issued
        chk("gloss readdr mvalid", mvalid, 1);
        chk("gloss readdr maddr", maddr, 16'h0300);
        sready = 1'b1;
        cyc();                       // DATA
        chk("gloss data rsp_valid", rsp_valid, 0);
        chk("gloss data mwdata", mwdata, 8'h11);
        cyc();                       // DONE
        chk("gloss done rsp_valid", rsp_valid, 1);
        sready = 1'b0;
        cyc();

        // ---------------- asynchronous reset during DATA ----------------
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0400;
        bgrant = 1'b1; sready = 1'b0;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();                       // DATA
        chk("rst pre breq", breq, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst async breq", breq, 0);
        chk("rst async mvalid", mvalid, 0);
        chk("rst async rsp_valid", rsp_valid, 0);
        chk("rst async req_ready", req_ready, 1);
        chk("rst async split_cnt", split_cnt, 0);
        sready = 1'b1;
        cyc();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || breq !== 1'b0)
                bad++;
        end
        chk("rst release quiet", bad, 0);
        sready = 1'b0;

        // ---------------- grant never arrives ----------------
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0500;
        bgrant = 1'b0;
        cyc();                       // REQ entered
        req_valid = 1'b0;
`ifdef BMC_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (rsp_valid !== 1'b0 || breq !== 1'b1)
                bad++;
        end
        chk("timeout wait breq held", bad, 0);
        cyc();                       // 16 cycles after entering REQ
        chk("timeout rsp_valid", rsp_valid, 1);
        chk("timeout rsp_err", rsp_err, 1);
        chk("timeout breq", breq, 0);
        cyc();
        chk("timeout idle req_ready", req_ready, 1);
        chk("timeout idle rsp_err", rsp_err, 0);
`else
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            cyc();
            if (breq === 1'b1)
                cnt++;
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0)
                bad++;
        end
        chk("no-timeout breq cycles", cnt, 120);
        chk("no-timeout no response", bad, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
